encoder_round_sequencer: RTL and testbench

- Top-level sequencer for the matrix-encoder datapath; runs one full encode per `start`.
- Sequence per encode:
  - LOAD: streams LINES memory lines into the state register, addressed by a line counter.
  - ROUNDS: runs ROUNDS rounds of five step phases (colParity, rotate, permute, revalute, addRC), each gated by a datapath acknowledge.
  - WRITE: streams the state back out, then pulses `done`.
- Replaces the flat controller/counter pair with explicit round and step tracking, an abort path and per-step handshakes.

---
 rtl/encoder_pkg.sv | 31 +++
 rtl/encoder_mod_counter.sv | 48 ++++
 rtl/encoder_round_sequencer.sv | 165 ++++++++++++++++
 tb/tb_encoder_round_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// ---------------------------------------------------------------------------
// encoder_pkg
// Shared types and constants for the matrix-encoder round sequencer.
//   state_e  : top-level sequencer states
//   step_e   : the five step phases that make up one round
//   LINES_C  : number of 25-bit state lines moved in LOAD and WRITE
//   ROUNDS_C : number of rounds per encode
// ---------------------------------------------------------------------------
package encoder_pkg;

    localparam int LINES_C  = 64;
    localparam int ROUNDS_C = 24;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        WRITE,
        DONE
    } state_e;

    // Encoding order matters: the step counter walks these values upward.
    typedef enum logic [2:0] {
        COLPARITY,
        ROTATE,
        PERMUTE,
        REVALUTE,
        ADDRC
    } step_e;

endpackage

// File: rtl/encoder_mod_counter.sv
// ---------------------------------------------------------------------------
// encoder_mod_counter
// Modulo-N up counter used for both the line counter and the round counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   en    : advance by one, wrapping from N-1 back to 0
//   clr   : synchronous clear, takes priority over en
//   count : current count value
//   co    : terminal count, high while count == N-1
// ---------------------------------------------------------------------------
module encoder_mod_counter #(
    parameter int N = 64,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         co
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign co    = (count_q == LAST);

endmodule

// File: rtl/encoder_round_sequencer.sv
// ---------------------------------------------------------------------------
// encoder_round_sequencer
// Top-level sequencer for the matrix-encoder datapath. One start runs a full
// encode: LOAD streams LINES lines in, STEP runs ROUNDS rounds of five
// acknowledged step phases, WRITE streams the state back out, DONE pulses.
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   start        : begin an encode (only honoured in IDLE)
//   abort        : synchronous cancel back to IDLE
//   step_ack     : datapath finished the current step phase
//   busy         : encode in progress (LOAD, STEP, WRITE)
//   done         : one-cycle completion pulse
//   mem_addr     : line address during LOAD and WRITE
//   load_en      : latch line_in at mem_addr into the state
//   wr_en        : write state line at mem_addr to memory
//   *_en (x5)    : one-hot step phase enables
//   round_idx    : current round for round-constant selection
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module encoder_round_sequencer
    import encoder_pkg::*;
#(
    parameter int LINES  = LINES_C,
    parameter int ROUNDS = ROUNDS_C,
    parameter int ADDR_W = 7,
    parameter int RND_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              step_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              load_en,
    output logic              wr_en,
    output logic              colParity_en,
    output logic              rotate_en,
    output logic              permute_en,
    output logic              revalute_en,
    output logic              addRC_en,
    output logic [RND_W-1:0]  round_idx
);

    state_e state_q, state_d;
    step_e  step_q, step_d;

    logic [ADDR_W-1:0] line_cnt;
    logic              line_co;
    logic              line_en;
    logic              line_clr;
    logic [RND_W-1:0]  round_cnt;
    logic              round_co;
    logic              round_en;
    logic              round_clr;

    encoder_mod_counter #(.N(LINES), .W(ADDR_W)) u_line_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (line_en),
        .clr   (line_clr),
        .count (line_cnt),
        .co    (line_co)
    );

    encoder_mod_counter #(.N(ROUNDS), .W(RND_W)) u_round_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (round_en),
        .clr   (round_clr),
        .count (round_cnt),
        .co    (round_co)
    );

    // Next-state and counter control. Abort outranks everything outside
    // IDLE, so an ack in the same cycle never advances the round. The
    // round counter is not bumped after the last round, which leaves
    // round_idx at ROUNDS-1 through WRITE and DONE.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        line_en   = 1'b0;
        line_clr  = 1'b0;
        round_en  = 1'b0;
        round_clr = 1'b0;

        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            step_d    = COLPARITY;
            line_clr  = 1'b1;
            round_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d   = LOAD;
                        step_d    = COLPARITY;
                        line_clr  = 1'b1;
                        round_clr = 1'b1;
                    end
                end
                LOAD: begin
                    line_en = 1'b1;
                    if (line_co) begin
                        state_d = STEP;
                        step_d  = COLPARITY;
                    end
                end
                STEP: begin
                    if (step_ack) begin
                        if (step_q == ADDRC) begin
                            step_d = COLPARITY;
                            if (round_co) begin
                                state_d  = WRITE;
                                line_clr = 1'b1;
                            end else begin
                                round_en = 1'b1;
                            end
                        end else begin
                            step_d = step_e'(step_q + 3'd1);
                        end
                    end
                end
                WRITE: begin
                    line_en = 1'b1;
                    if (line_co) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    step_d  = COLPARITY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= COLPARITY;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    assign busy         = (state_q == LOAD) || (state_q == STEP) || (state_q == WRITE);
    assign done         = (state_q == DONE);
    assign load_en      = (state_q == LOAD);
    assign wr_en        = (state_q == WRITE);
    assign mem_addr     = (load_en || wr_en) ? line_cnt : '0;
    assign colParity_en = (state_q == STEP) && (step_q == COLPARITY);
    assign rotate_en    = (state_q == STEP) && (step_q == ROTATE);
    assign permute_en   = (state_q == STEP) && (step_q == PERMUTE);
    assign revalute_en  = (state_q == STEP) && (step_q == REVALUTE);
    assign addRC_en     = (state_q == STEP) && (step_q == ADDRC);
    // The round counter keeps its last value after DONE; IDLE shows zero.
    assign round_idx    = (state_q == IDLE) ? '0 : round_cnt;

endmodule

// File: tb/tb_encoder_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_encoder_round_sequencer
// Self-checking bench. For each encode a reference transcript of the
// expected output vector per cycle is built from the sequence rules
// (LINES load beats, per-phase beats stretched by planned ack stalls,
// LINES write beats, one done beat) and compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_encoder_round_sequencer;

   localparam int LINES   = 64;
   localparam int ROUNDS  = 24;
   localparam int ADDR_W  = 7;
   localparam int RND_W   = 5;
   localparam int LATENCY = 2 * LINES + 5 * ROUNDS;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic stepAck = 1'b0;
   logic busy, done, loadEn, wrEn;
   logic colParityEn, rotateEn, permuteEn, revaluteEn, addRcEn;
   logic [ADDR_W-1:0] memAddr;
   logic [RND_W-1:0] roundIdx;

   typedef struct {
      logic [20:0] vec;
      logic        ack;
   } beat_t;

   beat_t plan[$];
   int stall[ROUNDS][5];
   int checks = 0;
   int failures = 0;
   int permuteRound5 = 0;

   encoder_round_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .step_ack     (stepAck),
      .busy         (busy),
      .done         (done),
      .mem_addr     (memAddr),
      .load_en      (loadEn),
      .wr_en        (wrEn),
      .colParity_en (colParityEn),
      .rotate_en    (rotateEn),
      .permute_en   (permuteEn),
      .revalute_en  (revaluteEn),
      .addRC_en     (addRcEn),
      .round_idx    (roundIdx)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] pack(input logic b, input logic d, input logic l,
                                        input logic w, input logic [4:0] en,
                                        input logic [6:0] addr, input logic [4:0] rnd);
      return {b, d, l, w, en, addr, rnd};
   endfunction

   function automatic logic [20:0] observed();
      return pack(busy, done, loadEn, wrEn,
                  {colParityEn, rotateEn, permuteEn, revaluteEn, addRcEn},
                  memAddr, roundIdx);
   endfunction

   task automatic checkOutput(input string tag, input logic [20:0] expVec);
      logic [20:0] obs;
      obs = observed();
      checks++;
      assert (obs === expVec) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expVec);
      end
   endtask

   task automatic checkInt(input string tag, input int obs, input int expVal);
      checks++;
      assert (obs === expVal) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expVal);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic ack);
      start   = s;
      abort   = a;
      stepAck = ack;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearStalls();
      foreach (stall[r, s]) stall[r][s] = 0;
   endtask

   // Expected transcript of one encode from the edge that samples start.
   function automatic int buildPlan();
      int extra = 0;
      plan.delete();
      for (int a = 0; a < LINES; a++)
         plan.push_back('{pack(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 7'(a), 5'd0), 1'($urandom_range(0, 1))});
      for (int r = 0; r < ROUNDS; r++)
         for (int s = 0; s < 5; s++) begin
            extra += stall[r][s];
            for (int k = 0; k <= stall[r][s]; k++)
               plan.push_back('{pack(1'b1, 1'b0, 1'b0, 1'b0, 5'b10000 >> s, 7'd0, 5'(r)),
                                (k == stall[r][s]) ? 1'b1 : 1'b0});
         end
      for (int a = 0; a < LINES; a++)
         plan.push_back('{pack(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 7'(a), 5'(ROUNDS - 1)), 1'($urandom_range(0, 1))});
      plan.push_back('{pack(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 7'd0, 5'(ROUNDS - 1)), 1'($urandom_range(0, 1))});
      return extra;
   endfunction

   // Launch an encode from IDLE and follow the transcript. Optionally abort
   // or assert reset at a given beat; noisyStart pulses start while busy.
   task automatic runPlan(input int abortAt, input int resetAt, input bit noisyStart,
                          output int doneBeat);
      logic s;
      doneBeat = -1;
      permuteRound5 = 0;
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      tick();
      for (int i = 0; i < plan.size(); i++) begin
         checkOutput($sformatf("beat%0d", i), plan[i].vec);
         if (done === 1'b1 && doneBeat < 0) doneBeat = i;
         if (permuteEn === 1'b1 && roundIdx === 5'd5) permuteRound5++;
         if (i == abortAt) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            tick();
            checkOutput("abortToIdle", 21'd0);
            applyStimulus(1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
               tick();
               checkOutput("idleAfterAbort", 21'd0);
               if (done === 1'b1) doneBeat = i;
            end
            return;
         end
         if (i == resetAt) begin
            #2 rst = 1'b0;
            #1 checkOutput("asyncResetImmediate", 21'd0);
            applyStimulus(1'b0, 1'b0, 1'b0);
            tick();
            checkOutput("resetHeld", 21'd0);
            rst = 1'b1;
            for (int k = 0; k < 3; k++) begin
               tick();
               checkOutput("idleAfterReset", 21'd0);
               if (done === 1'b1) doneBeat = i;
            end
            return;
         end
         s = noisyStart ? ((i == 10 || i == 100 || i == plan.size() - 1) ? 1'b1
                                                                         : 1'($urandom_range(0, 1)))
                        : 1'b0;
         applyStimulus(s, 1'b0, plan[i].ack);
         tick();
      end
      checkOutput("idleAfterDone", 21'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int doneBeat;
      int extra;

      // Reset held: everything zero, before and across clock edges.
      applyStimulus(1'b0, 1'b0, 1'b0);
      #2 checkOutput("resetHold", 21'd0);
      repeat (2) @(posedge clk);
      #1 checkOutput("resetHoldEdges", 21'd0);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         tick();
         checkOutput("idleNoStart", 21'd0);
      end

      // Abort together with start in IDLE keeps the FSM idle.
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick();
      checkOutput("abortBeatsStart", 21'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("stillIdle", 21'd0);

      $display("[TB] nominal encode");
      clearStalls();
      extra = buildPlan();
      runPlan(-1, -1, 1'b0, doneBeat);
      checkInt("nominalLatency", doneBeat, LATENCY);

      $display("[TB] ack stall round 5 step 2");
      clearStalls();
      stall[5][2] = 3;
      extra = buildPlan();
      runPlan(-1, -1, 1'b0, doneBeat);
      checkInt("stallLatency", doneBeat, LATENCY + 3);
      checkInt("permuteStretch", permuteRound5, 4);

      $display("[TB] start while busy, then back-to-back start");
      clearStalls();
      extra = buildPlan();
      runPlan(-1, -1, 1'b1, doneBeat);
      checkInt("noisyStartLatency", doneBeat, LATENCY);
      extra = buildPlan();
      runPlan(-1, -1, 1'b0, doneBeat);
      checkInt("backToBackLatency", doneBeat, LATENCY);

      $display("[TB] abort in round 10 with ack high");
      clearStalls();
      extra = buildPlan();
      runPlan(LINES + 10 * 5 + 2, -1, 1'b0, doneBeat);
      checkInt("abortNoDone", doneBeat, -1);
      extra = buildPlan();
      runPlan(-1, -1, 1'b0, doneBeat);
      checkInt("afterAbortLatency", doneBeat, LATENCY);

      $display("[TB] randomized ack stalls");
      for (int run = 0; run < 2; run++) begin
         foreach (stall[r, s]) stall[r][s] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         extra = buildPlan();
         runPlan(-1, -1, 1'b1, doneBeat);
         checkInt("randomStallLatency", doneBeat, LATENCY + extra);
      end

      $display("[TB] async reset at writeback line 30");
      clearStalls();
      extra = buildPlan();
      runPlan(-1, LINES + 5 * ROUNDS + 30, 1'b0, doneBeat);
      checkInt("resetNoDone", doneBeat, -1);
      extra = buildPlan();
      runPlan(-1, -1, 1'b0, doneBeat);
      checkInt("afterResetLatency", doneBeat, LATENCY);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
